// File: rtl/ahb_wr_mnt.sv
`default_nettype none
// ============================================================================
// Module   : ahb_wr_mnt
// Brief    : Passive AHB-Lite write snooper decoding a mailbox (pass/fail
//            verdict, printf character FIFO) and a register-dump window.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_wr_mnt #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] MBOX_ADDR   = 32'h20007c50,
    parameter logic [31:0]       PASS_CODE   = 32'h2002,
    parameter logic [31:0]       FAIL_CODE   = 32'h1001,
    parameter int                MARK_REPEAT = 2,
    parameter logic [ADDR_W-1:0] GPR_BASE    = 32'h20007c60,
    parameter int                NUM_GPR     = 16,
    parameter int                CHAR_DEPTH  = 8
) (
    input  logic                       sysclk,
    input  logic                       sysrst_b,
    input  logic                       ahb_hsel,
    input  logic [1:0]                 ahb_htrans,
    input  logic                       ahb_hwrite,
    input  logic [ADDR_W-1:0]          ahb_haddr,
    input  logic [DATA_W-1:0]          ahb_hwdata,
    input  logic                       ahb_hready,
    output logic                       char_vld,
    output logic [7:0]                 char_data,
    input  logic                       char_rdy,
    output logic [7:0]                 char_ovf_cnt,
    output logic                       test_pass,
    output logic                       test_fail,
    output logic                       gpr_done,
    input  logic [$clog2(NUM_GPR)-1:0] gpr_rd_idx,
    output logic [DATA_W-1:0]          gpr_rd_data
);

    localparam int         IDX_W    = $clog2(NUM_GPR);
    localparam int         PTR_W    = $clog2(CHAR_DEPTH);
    localparam logic [3:0] MARK_CNT = 4'(MARK_REPEAT);

    logic                    pend;
    logic [ADDR_W-1:0]       addr_q;
    logic                    accept;
    logic                    complete;

    logic [3:0]              pass_cnt;
    logic [3:0]              fail_cnt;
    logic                    mbox_wr;
    logic                    is_pass;
    logic                    is_fail;

    logic [7:0]              fifo_mem [CHAR_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W:0]          fifo_cnt;
    logic                    fifo_full;
    logic                    push_req;
    logic                    push_ok;
    logic                    pop;
    logic                    drop;

    logic [DATA_W-1:0]       gpr [NUM_GPR];
    logic [ADDR_W-1:0]       gpr_off;
    logic [IDX_W-1:0]        gpr_idx;
    logic                    gpr_hit;

    // Comparing against both active encodings keeps every htrans bit in use.
    assign accept   = ahb_hsel & ahb_hready & ahb_hwrite &
                      ((ahb_htrans == 2'b10) | (ahb_htrans == 2'b11));
    assign complete = pend & ahb_hready;

    always_comb begin
        mbox_wr   = complete & (addr_q == MBOX_ADDR) & ~(test_pass | test_fail);
        is_pass   = (ahb_hwdata == DATA_W'(PASS_CODE));
        is_fail   = (ahb_hwdata == DATA_W'(FAIL_CODE));
        push_req  = mbox_wr & ~is_pass & ~is_fail;
        fifo_full = (fifo_cnt == (PTR_W+1)'(CHAR_DEPTH));
        char_vld  = (fifo_cnt != '0);
        pop       = char_vld & char_rdy;
        push_ok   = push_req & (~fifo_full | pop);
        drop      = push_req & ~push_ok;
        char_data = char_vld ? fifo_mem[rd_ptr] : 8'h00;
        gpr_off   = addr_q - GPR_BASE;
        gpr_idx   = gpr_off[IDX_W+1:2];
        gpr_hit   = complete & (addr_q >= GPR_BASE) &
                    (gpr_off < ADDR_W'(4*NUM_GPR)) & (addr_q[1:0] == 2'b00);
    end

    always_ff @(posedge sysclk or negedge sysrst_b) begin
        if (!sysrst_b) begin
            pend         <= 1'b0;
            addr_q       <= '0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            test_pass    <= 1'b0;
            test_fail    <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            char_ovf_cnt <= '0;
            gpr_done     <= 1'b0;
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr[i] <= '0;
            end
        end else begin
            // A fresh accept on the completing edge re-arms the data phase.
            if (accept) begin
                pend   <= 1'b1;
                addr_q <= ahb_haddr;
            end else if (complete) begin
                pend   <= 1'b0;
            end

            if (mbox_wr) begin
                if (is_pass) begin
                    pass_cnt <= pass_cnt + 4'd1;
                    fail_cnt <= '0;
                    if (pass_cnt + 4'd1 == MARK_CNT) test_pass <= 1'b1;
                end else if (is_fail) begin
                    fail_cnt <= fail_cnt + 4'd1;
                    pass_cnt <= '0;
                    if (fail_cnt + 4'd1 == MARK_CNT) test_fail <= 1'b1;
                end else begin
                    pass_cnt <= '0;
                    fail_cnt <= '0;
                end
            end

            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (drop && (char_ovf_cnt != 8'hff)) char_ovf_cnt <= char_ovf_cnt + 8'd1;

            if (gpr_hit) begin
                gpr[gpr_idx] <= ahb_hwdata;
                if (gpr_idx == IDX_W'(NUM_GPR-1)) gpr_done <= 1'b1;
            end
        end
    end

    // Character storage needs no reset: char_data is masked while empty.
    always_ff @(posedge sysclk) begin
        if (push_ok) fifo_mem[wr_ptr] <= ahb_hwdata[7:0];
    end

    generate
        if (NUM_GPR == (1 << IDX_W)) begin : g_rd_pow2
            assign gpr_rd_data = gpr[gpr_rd_idx];
        end else begin : g_rd_npow2
            assign gpr_rd_data = (gpr_rd_idx < IDX_W'(NUM_GPR)) ? gpr[gpr_rd_idx] : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ahb_wr_mnt.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_wr_mnt
// Brief    : Directed self-checking bench for the AHB write snooper.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_wr_mnt;

    localparam logic [31:0] MBOX = 32'h20007c50;
    localparam logic [31:0] PASS = 32'h2002;
    localparam logic [31:0] FAIL = 32'h1001;
    localparam logic [31:0] GPRB = 32'h20007c60;

    logic        sysclk = 1'b0;
    logic        sysrst_b = 1'b0;
    logic        ahb_hsel = 1'b1;
    logic [1:0]  ahb_htrans = 2'b00;
    logic        ahb_hwrite = 1'b0;
    logic [31:0] ahb_haddr = '0;
    logic [31:0] ahb_hwdata = '0;
    logic        ahb_hready = 1'b1;
    logic        char_vld;
    logic [7:0]  char_data;
    logic        char_rdy = 1'b0;
    logic [7:0]  char_ovf_cnt;
    logic        test_pass;
    logic        test_fail;
    logic        gpr_done;
    logic [3:0]  gpr_rd_idx = '0;
    logic [31:0] gpr_rd_data;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    ahb_wr_mnt dut (
        .sysclk       (sysclk),
        .sysrst_b     (sysrst_b),
        .ahb_hsel     (ahb_hsel),
        .ahb_htrans   (ahb_htrans),
        .ahb_hwrite   (ahb_hwrite),
        .ahb_haddr    (ahb_haddr),
        .ahb_hwdata   (ahb_hwdata),
        .ahb_hready   (ahb_hready),
        .char_vld     (char_vld),
        .char_data    (char_data),
        .char_rdy     (char_rdy),
        .char_ovf_cnt (char_ovf_cnt),
        .test_pass    (test_pass),
        .test_fail    (test_fail),
        .gpr_done     (gpr_done),
        .gpr_rd_idx   (gpr_rd_idx),
        .gpr_rd_data  (gpr_rd_data)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        sysrst_b = 1'b0;
        tick();
        tick();
        sysrst_b = 1'b1;
        tick();
    endtask

    // Single transfer: address phase, optional wait states, then data phase.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input int waits,
                      input logic [1:0] tr = 2'b10);
        ahb_htrans = tr;
        ahb_hwrite = 1'b1;
        ahb_haddr  = a;
        ahb_hready = 1'b1;
        tick();
        ahb_htrans = 2'b00;
        ahb_hwrite = 1'b0;
        ahb_hwdata = d;
        ahb_hready = 1'b0;
        repeat (waits) tick();
        ahb_hready = 1'b1;
        tick();
    endtask

    initial begin
        do_reset();
        check("rst_pass", {31'd0, test_pass}, 32'd0);
        check("rst_fail", {31'd0, test_fail}, 32'd0);
        check("rst_vld", {31'd0, char_vld}, 32'd0);
        check("rst_ovf", {24'd0, char_ovf_cnt}, 32'd0);
        check("rst_done", {31'd0, gpr_done}, 32'd0);

        // 1: two PASS codes give a verdict; later mailbox traffic is ignored
        wr(MBOX, PASS, 0);
        check("t1_pass_after1", {31'd0, test_pass}, 32'd0);
        wr(MBOX, PASS, 0);
        check("t1_pass_after2", {31'd0, test_pass}, 32'd1);
        check("t1_fail", {31'd0, test_fail}, 32'd0);
        wr(MBOX, 32'h5a, 0);
        check("t1_locked_vld", {31'd0, char_vld}, 32'd0);

        // 2: an intervening character clears the PASS run
        do_reset();
        wr(MBOX, PASS, 0);
        wr(MBOX, 32'h41, 0);
        wr(MBOX, PASS, 0);
        check("t2_pass", {31'd0, test_pass}, 32'd0);
        check("t2_vld", {31'd0, char_vld}, 32'd1);
        check("t2_data", {24'd0, char_data}, 32'h41);

        // 3: overflow of an unread FIFO, then drain in order
        do_reset();
        for (int i = 0; i < 10; i++) wr(MBOX, 32'h61 + i, 0);
        check("t3_ovf", {24'd0, char_ovf_cnt}, 32'd2);
        for (int i = 0; i < 8; i++) begin
            check("t3_drain_vld", {31'd0, char_vld}, 32'd1);
            check("t3_drain_data", {24'd0, char_data}, 32'h61 + i);
            char_rdy = 1'b1;
            tick();
            char_rdy = 1'b0;
        end
        check("t3_empty", {31'd0, char_vld}, 32'd0);

        // 4: pipelined dump writes, two wait states each
        ahb_htrans = 2'b10;
        ahb_hwrite = 1'b1;
        ahb_haddr  = GPRB;
        ahb_hready = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            ahb_hwdata = 32'h11 + i;
            if (i < 15) begin
                ahb_htrans = 2'b11;
                ahb_haddr  = GPRB + 32'(4 * (i + 1));
            end else begin
                ahb_htrans = 2'b00;
                ahb_hwrite = 1'b0;
            end
            ahb_hready = 1'b0;
            tick();
            tick();
            ahb_hready = 1'b1;
            tick();
            if (i == 14) check("t4_done_early", {31'd0, gpr_done}, 32'd0);
        end
        check("t4_done", {31'd0, gpr_done}, 32'd1);
        gpr_rd_idx = 4'd0;  #1 check("t4_gpr0", gpr_rd_data, 32'h11);
        gpr_rd_idx = 4'd7;  #1 check("t4_gpr7", gpr_rd_data, 32'h18);
        gpr_rd_idx = 4'd15; #1 check("t4_gpr15", gpr_rd_data, 32'h20);

        // 5: reset asserted during a wait state discards the pending write
        wr(MBOX, FAIL, 0);
        ahb_htrans = 2'b10;
        ahb_hwrite = 1'b1;
        ahb_haddr  = MBOX;
        tick();
        ahb_htrans = 2'b00;
        ahb_hwrite = 1'b0;
        ahb_hwdata = FAIL;
        ahb_hready = 1'b0;
        tick();
        #1 sysrst_b = 1'b0;
        #1;
        check("t5_async_done", {31'd0, gpr_done}, 32'd0);
        check("t5_async_gpr", gpr_rd_data, 32'd0);
        check("t5_async_fail", {31'd0, test_fail}, 32'd0);
        tick();
        sysrst_b   = 1'b1;
        ahb_hready = 1'b1;
        tick();
        tick();
        wr(MBOX, FAIL, 0);
        check("t5_single_fail", {31'd0, test_fail}, 32'd0);

        // 6: unaligned dump write and a BUSY mailbox write do nothing
        wr(GPRB + 32'd2, 32'hdead, 0);
        gpr_rd_idx = 4'd0; #1 check("t6_gpr0", gpr_rd_data, 32'd0);
        wr(MBOX, FAIL, 0, 2'b01);
        check("t6_busy_fail", {31'd0, test_fail}, 32'd0);
        check("t6_vld", {31'd0, char_vld}, 32'd0);
        wr(MBOX, FAIL, 0);
        check("t6_real_fail", {31'd0, test_fail}, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
